// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared defaults and FSM state encoding for the bitcell array controller
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W        = 4;
    localparam int DEF_DATA_W        = 8;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int CNT_W             = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/row_decoder.sv
// rtl/row_decoder.sv - word address to one-hot row select with enable
module row_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] sel
);

    localparam int ROWS = 1 << ADDR_W;

    assign sel = en ? (ROWS'(1) << addr) : '0;

endmodule

// File: rtl/bitcell_array_ctrl.sv
// rtl/bitcell_array_ctrl.sv - setup/strobe/release sequencer driving a shared-bus bitcell array
module bitcell_array_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   ready,
    output logic                   done,
    output logic [DATA_W-1:0]      rdata,
    output logic [(1<<ADDR_W)-1:0] cell_sel,
    output logic                   cell_rw,
    output logic [DATA_W-1:0]      cell_in,
    input  logic [DATA_W-1:0]      cell_out
);

    logic [1:0]        state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              active;
    logic              strobe_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt   <= CNT_W'(STROBE_CYCLES - 1);
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    // Read bus is sampled on the last strobe edge, while the row is still selected.
                    if (cnt == '0) begin
                        state <= ST_RELEASE;
                        if (!we_q) begin
                            rdata <= cell_out;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // rw/in are held from SETUP through RELEASE so they are stable around the select pulse.
    assign active    = (state != ST_IDLE);
    assign strobe_en = (state == ST_STROBE);
    assign ready     = (state == ST_IDLE);
    assign done      = (state == ST_RELEASE);
    assign cell_rw   = active & we_q;
    assign cell_in   = (active && we_q) ? wdata_q : '0;

    row_decoder #(
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .en   (strobe_en),
        .addr (addr_q),
        .sel  (cell_sel)
    );

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// tb/tb_bitcell_array_ctrl.sv - self-checking bench with behavioural bitcell array and reference memory
module tb_bitcell_array_ctrl;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int S    = 2;
    localparam int ROWS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready;
    logic          done;
    logic [DW-1:0] rdata;
    logic [ROWS-1:0] cell_sel;
    logic          cell_rw;
    logic [DW-1:0] cell_in;
    logic [DW-1:0] cell_out;

    int checks = 0;
    int errors = 0;

    bitcell_array_ctrl #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .STROBE_CYCLES (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .rdata    (rdata),
        .cell_sel (cell_sel),
        .cell_rw  (cell_rw),
        .cell_in  (cell_in),
        .cell_out (cell_out)
    );

    always #5 clk = ~clk;

    // Behavioural bitcells on the shared nets
    logic [DW-1:0] cells [ROWS];
    logic [DW-1:0] cell_out_r;

    initial begin
        for (int i = 0; i < ROWS; i++) cells[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (cell_sel[i] && cell_rw) cells[i] <= cell_in;
        end
    end

    always @* begin
        cell_out_r = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (cell_sel[i]) cell_out_r = cell_out_r | cells[i];
        end
    end
    assign cell_out = cell_out_r;

    // Reference model: plain word array plus last read value
    logic [DW-1:0] ref_mem [ROWS];
    logic [DW-1:0] exp_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus-protocol monitor
    logic [ROWS-1:0] prev_sel;
    logic            prev_rw;
    logic [DW-1:0]   prev_in;
    bit              mon_skip = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            mon_skip = 1'b1;
        end else begin
            chk("sel_onehot0", 32'($onehot0(cell_sel)), 32'd1);
            if (!mon_skip) begin
                if (prev_sel != '0 && cell_sel != '0) begin
                    chk("rw_stable_while_sel", cell_rw, prev_rw);
                    chk("in_stable_while_sel", cell_in, prev_in);
                end
                if (cell_sel != prev_sel) chk("sel_rw_same_edge", cell_rw, prev_rw);
            end
            mon_skip = 1'b0;
        end
        prev_sel = cell_sel;
        prev_rw  = cell_rw;
        prev_in  = cell_in;
    end

    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_rd, input bit scramble);
        int n;
        int lat;
        logic [ROWS-1:0] onehot;
        onehot = ROWS'(1) << a;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", ready, 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        for (int c = 1; c <= S + 4; c++) begin
            if (scramble) begin
                we    = 1'($urandom_range(0, 1));
                addr  = AW'($urandom);
                wdata = DW'($urandom);
            end
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            chk("cell_sel", cell_sel, (c >= 2 && c <= S + 1) ? onehot : '0);
            chk("cell_rw", cell_rw, w);
            chk("cell_in", cell_in, w ? d : '0);
            chk("ready_busy", ready, 0);
        end
        chk("latency", lat, S + 2);
        chk("rdata", rdata, exp_rd);
        chk("release_rw", cell_rw, w);
        chk("release_sel", cell_sel, 0);
        @(negedge clk);
        chk("idle_rw", cell_rw, 0);
        chk("idle_in", cell_in, 0);
        chk("idle_done", done, 0);
        chk("idle_ready", ready, 1);
        exp_last = exp_rd;
    endtask

    task automatic run_ref(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit scramble);
        logic [DW-1:0] e;
        e = w ? exp_last : ref_mem[a];
        txn(w, a, d, e, scramble);
        if (w) ref_mem[a] = d;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int acc_cnt;
        int dones;
        int acc_t [3];
        bit acc;

        vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
        vecs[2] = '{1'b1, 4'd0,  8'h00, 8'hA5};
        vecs[3] = '{1'b1, 4'd15, 8'hFF, 8'hA5};
        vecs[4] = '{1'b0, 4'd0,  8'h00, 8'h00};
        vecs[5] = '{1'b0, 4'd15, 8'h00, 8'hFF};
        vecs[6] = '{1'b0, 4'd3,  8'h00, 8'hA5};
        vecs[7] = '{1'b1, 4'd8,  8'h5A, 8'hA5};
        vecs[8] = '{1'b0, 4'd8,  8'h00, 8'h5A};

        for (int i = 0; i < ROWS; i++) ref_mem[i] = '0;
        exp_last = '0;

        // Reset state
        req = 1'b1; we = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sel", cell_sel, 0);
        chk("rst_rw", cell_rw, 0);
        chk("rst_in", cell_in, 0);
        req = 1'b0; we = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
            if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wdata;
        end

        // In-flight input changes
        run_ref(1'b1, 4'd5, 8'hC3, 1'b1);
        run_ref(1'b0, 4'd5, 8'h00, 1'b1);

        // req held high across three back-to-back transactions
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd7; wdata = 8'h3C;
        acc_cnt = 0; dones = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (done) begin
                case (dones)
                    0: chk("b2b_rdata_after_write", rdata, exp_last);
                    1: chk("b2b_rdata_read7", rdata, 8'h3C);
                    default: chk("b2b_rdata_read3", rdata, ref_mem[3]);
                endcase
                dones++;
            end
            acc = ready && req;
            @(posedge clk);
            #1;
            if (acc) begin
                if (acc_cnt < 3) acc_t[acc_cnt] = cyc;
                acc_cnt++;
                case (acc_cnt)
                    1: begin we = 1'b0; addr = 4'd7; end
                    2: begin we = 1'b0; addr = 4'd3; end
                    default: req = 1'b0;
                endcase
            end
            @(negedge clk);
        end
        req = 1'b0;
        chk("b2b_accepts", acc_cnt, 3);
        chk("b2b_dones", dones, 3);
        if (acc_cnt >= 3) begin
            chk("b2b_spacing_1", acc_t[1] - acc_t[0], S + 3);
            chk("b2b_spacing_2", acc_t[2] - acc_t[1], S + 3);
        end
        ref_mem[7] = 8'h3C;
        exp_last = ref_mem[3];

        // Reset during the strobe of a read
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 4'd15;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_strobe", cell_sel, 16'h8000);
        #2;
        rst = 1'b1; req = 1'b1; we = 1'b1;
        #1;
        chk("mid_rst_sel", cell_sel, 0);
        chk("mid_rst_rw", cell_rw, 0);
        chk("mid_rst_in", cell_in, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_ready", ready, 1);
        @(posedge clk);
        #1;
        chk("rst_no_accept_rw", cell_rw, 0);
        chk("rst_no_accept_ready", ready, 1);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        rst = 1'b0;
        exp_last = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
        end
        run_ref(1'b0, 4'd15, 8'h00, 1'b0);
        run_ref(1'b0, 4'd3, 8'h00, 1'b0);

        // Randomised traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            run_ref(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
